// File: rtl/pipe_memory_stage.sv
// rtl/pipe_memory_stage.sv - load/store stage: one latched bus transaction per request, load extension
// Holds the pipe while the bus access runs; a held request is not replayed after DONE.
module pipe_memory_stage #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stepPipe,
   input  logic        memoryEnable,
   input  logic        memoryWriteEnable,
   input  logic [3:0]  memoryByteSelect,
   input  logic [31:0] memoryAddress,
   input  logic [31:0] memoryWriteData,
   input  logic [2:0]  loadFunct3,
   input  logic [4:0]  loadRdIndex,
   output logic        stallRequest,
   output logic        loadResultValid,
   output logic [4:0]  loadResultRd,
   output logic [31:0] loadResult,
   output logic        busError,
   output logic        bus_enable,
   output logic        bus_writeEnable,
   output logic [3:0]  bus_byteSelect,
   output logic [31:0] bus_address,
   output logic [31:0] bus_writeData,
   input  logic        bus_ack,
   input  logic [31:0] bus_readData
);

   typedef enum logic [1:0] {IDLE, BUS, DONE, BUS_ERROR} state_t;

   localparam logic        TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  bsel_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q;
   logic [31:0] cnt_q;
   logic [31:0] result_q;
   logic [4:0]  result_rd_q;

   logic [1:0]  lane_offset;
   logic [31:0] shifted;
   logic [31:0] result_d;

   // Lowest selected lane decides the shift; an empty select falls back to lane 0.
   always_comb begin
      lane_offset = 2'd0;
      if (bsel_q[0])      lane_offset = 2'd0;
      else if (bsel_q[1]) lane_offset = 2'd1;
      else if (bsel_q[2]) lane_offset = 2'd2;
      else if (bsel_q[3]) lane_offset = 2'd3;
      shifted = bus_readData >> {lane_offset, 3'b000};
      case (funct3_q)
         3'b000:  result_d = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  result_d = {{16{shifted[15]}}, shifted[15:0]};
         3'b010:  result_d = shifted;
         3'b100:  result_d = {24'd0, shifted[7:0]};
         3'b101:  result_d = {16'd0, shifted[15:0]};
         default: result_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         bsel_q      <= 4'd0;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         rd_q        <= 5'd0;
         cnt_q       <= 32'd0;
         result_q    <= 32'd0;
         result_rd_q <= 5'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (memoryEnable) begin
                  state_q  <= BUS;
                  addr_q   <= memoryAddress;
                  wdata_q  <= memoryWriteData;
                  bsel_q   <= memoryByteSelect;
                  we_q     <= memoryWriteEnable;
                  funct3_q <= loadFunct3;
                  rd_q     <= loadRdIndex;
                  cnt_q    <= 32'd0;
               end
            end
            BUS: begin
               cnt_q <= cnt_q + 32'd1;
               if (bus_ack) begin
                  state_q     <= DONE;
                  result_q    <= result_d;
                  result_rd_q <= rd_q;
               end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                  state_q <= BUS_ERROR;
               end
            end
            DONE: begin
               if (stepPipe) state_q <= IDLE;
            end
            BUS_ERROR: begin
               if (stepPipe) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset gates the IDLE pass-through so every output is low while rst is held.
   assign stallRequest    = (state_q == BUS) | ((state_q == IDLE) & memoryEnable & rst);
   assign loadResultValid = (state_q == DONE) & ~we_q;
   assign busError        = (state_q == BUS_ERROR);
   assign loadResult      = result_q;
   assign loadResultRd    = result_rd_q;

   assign bus_enable      = (state_q == BUS);
   assign bus_writeEnable = bus_enable & we_q;
   assign bus_byteSelect  = bus_enable ? bsel_q  : 4'd0;
   assign bus_address     = bus_enable ? addr_q  : 32'd0;
   assign bus_writeData   = bus_enable ? wdata_q : 32'd0;

endmodule

// File: tb/tb_pipe_memory_stage.sv
// tb/tb_pipe_memory_stage.sv - directed vector bench for pipe_memory_stage
// Load-extension table plus hand-written store, timeout and reset sequences.
module tb_pipe_memory_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stepPipe = 1'b0;
   logic        memoryEnable = 1'b0;
   logic        memoryWriteEnable = 1'b0;
   logic [3:0]  memoryByteSelect = 4'd0;
   logic [31:0] memoryAddress = 32'd0;
   logic [31:0] memoryWriteData = 32'd0;
   logic [2:0]  loadFunct3 = 3'd0;
   logic [4:0]  loadRdIndex = 5'd0;
   logic        stallRequest;
   logic        loadResultValid;
   logic [4:0]  loadResultRd;
   logic [31:0] loadResult;
   logic        busError;
   logic        bus_enable;
   logic        bus_writeEnable;
   logic [3:0]  bus_byteSelect;
   logic [31:0] bus_address;
   logic [31:0] bus_writeData;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_readData = 32'd0;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_memory_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .stepPipe(stepPipe),
      .memoryEnable(memoryEnable), .memoryWriteEnable(memoryWriteEnable),
      .memoryByteSelect(memoryByteSelect), .memoryAddress(memoryAddress),
      .memoryWriteData(memoryWriteData), .loadFunct3(loadFunct3),
      .loadRdIndex(loadRdIndex), .stallRequest(stallRequest),
      .loadResultValid(loadResultValid), .loadResultRd(loadResultRd),
      .loadResult(loadResult), .busError(busError),
      .bus_enable(bus_enable), .bus_writeEnable(bus_writeEnable),
      .bus_byteSelect(bus_byteSelect), .bus_address(bus_address),
      .bus_writeData(bus_writeData), .bus_ack(bus_ack),
      .bus_readData(bus_readData)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [3:0]  bsel;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issues one request at a negedge and runs the BUS phase; ack_at=0 never acks.
   task automatic access(input logic we, input logic [3:0] bsel, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_at, output int be_cnt);
      @(negedge clk);
      memoryEnable = 1'b1; memoryWriteEnable = we; memoryByteSelect = bsel;
      memoryAddress = addr; memoryWriteData = wdata; loadFunct3 = f3;
      loadRdIndex = rd; stepPipe = 1'b0;
      #1 check("stall_idle_req", 32'(stallRequest), 32'd1);
      @(negedge clk);
      be_cnt = 0;
      for (int c = 0; c < 64 && bus_enable; c++) begin
         be_cnt++;
         check("bus_address", bus_address, addr);
         check("bus_byteSelect", 32'(bus_byteSelect), 32'(bsel));
         check("bus_writeData", bus_writeData, wdata);
         check("bus_writeEnable", 32'(bus_writeEnable), 32'(we));
         check("stall_bus", 32'(stallRequest), 32'd1);
         memoryAddress = ~addr;
         memoryByteSelect = ~bsel;
         memoryWriteData = ~wdata;
         bus_ack = (be_cnt == ack_at);
         bus_readData = rdata;
         @(negedge clk);
      end
      bus_ack = 1'b0;
      bus_readData = 32'd0;
   endtask

   task automatic step_idle();
      stepPipe = 1'b1;
      memoryEnable = 1'b0;
      @(negedge clk);
      stepPipe = 1'b0;
      check("idle_stall", 32'(stallRequest), 32'd0);
      check("idle_valid", 32'(loadResultValid), 32'd0);
      check("idle_busError", 32'(busError), 32'd0);
      check("idle_bus_enable", 32'(bus_enable), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int be;
      vecs[0] = '{3'b000, 4'b0100, 32'h12803456, 32'hFFFFFF80};
      vecs[1] = '{3'b100, 4'b0100, 32'h12803456, 32'h00000080};
      vecs[2] = '{3'b101, 4'b1100, 32'hBEEF1234, 32'h0000BEEF};
      vecs[3] = '{3'b001, 4'b1100, 32'hBEEF1234, 32'hFFFFBEEF};
      vecs[4] = '{3'b000, 4'b0001, 32'h0000007F, 32'h0000007F};
      vecs[5] = '{3'b001, 4'b0011, 32'h00008001, 32'hFFFF8001};
      vecs[6] = '{3'b011, 4'b1111, 32'h12345678, 32'h00000000};
      vecs[7] = '{3'b100, 4'b1000, 32'hAB000000, 32'h000000AB};
      vecs[8] = '{3'b000, 4'b0000, 32'h000000F0, 32'hFFFFFFF0};
      vecs[9] = '{3'b010, 4'b1111, 32'h89ABCDEF, 32'h89ABCDEF};

      // Reset state, with a request already asserted
      memoryEnable = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_stall", 32'(stallRequest), 32'd0);
      check("rst_outputs", {24'd0, loadResultValid, busError, bus_enable, bus_writeEnable, bus_byteSelect}, 32'd0);
      check("rst_loadResult", loadResult, 32'd0);
      check("rst_rd", 32'(loadResultRd), 32'd0);
      check("rst_bus_address", bus_address, 32'd0);
      memoryEnable = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("idle_no_req_stall", 32'(stallRequest), 32'd0);

      // LW, ack in the 3rd bus cycle, DONE held while the pipe stays stalled
      access(1'b0, 4'b1111, 3'b010, 5'd7, 32'h100, 32'd0, 32'hDEADBEEF, 3, be);
      check("lw_burst_len", 32'(be), 32'd3);
      for (int k = 0; k < 2; k++) begin
         check("lw_valid", 32'(loadResultValid), 32'd1);
         check("lw_result", loadResult, 32'hDEADBEEF);
         check("lw_rd", 32'(loadResultRd), 32'd7);
         check("lw_stall", 32'(stallRequest), 32'd0);
         check("lw_done_bus_enable", 32'(bus_enable), 32'd0);
         @(negedge clk);
      end
      step_idle();

      // Extension table, ack in the first bus cycle
      for (int i = 0; i < 10; i++) begin
         access(1'b0, vecs[i].bsel, vecs[i].f3, 5'(i + 1), 32'h200 + 32'(4 * i), 32'd0,
                vecs[i].rdata, 1, be);
         check("vec_burst_len", 32'(be), 32'd1);
         check("vec_valid", 32'(loadResultValid), 32'd1);
         check("vec_result", loadResult, vecs[i].exp);
         check("vec_rd", 32'(loadResultRd), 32'(i + 1));
         step_idle();
      end

      // SW with a held request: no replay, then a fresh access right after stepping
      access(1'b1, 4'b1111, 3'b010, 5'd9, 32'h300, 32'hCAFEF00D, 32'd0, 2, be);
      check("sw_burst_len", 32'(be), 32'd2);
      for (int k = 0; k < 5; k++) begin
         check("sw_no_replay", 32'(bus_enable), 32'd0);
         check("sw_valid", 32'(loadResultValid), 32'd0);
         check("sw_stall", 32'(stallRequest), 32'd0);
         @(negedge clk);
      end
      stepPipe = 1'b1;
      memoryWriteEnable = 1'b0; memoryByteSelect = 4'b1111; loadFunct3 = 3'b010;
      memoryAddress = 32'h340; loadRdIndex = 5'd11;
      @(negedge clk);
      stepPipe = 1'b0;
      check("sw_next_idle_bus", 32'(bus_enable), 32'd0);
      check("sw_next_idle_stall", 32'(stallRequest), 32'd1);
      @(negedge clk);
      check("sw_next_bus", 32'(bus_enable), 32'd1);
      check("sw_next_addr", bus_address, 32'h340);
      bus_ack = 1'b1; bus_readData = 32'h0BADF00D;
      @(negedge clk);
      bus_ack = 1'b0;
      check("sw_next_valid", 32'(loadResultValid), 32'd1);
      check("sw_next_result", loadResult, 32'h0BADF00D);
      check("sw_next_rd", 32'(loadResultRd), 32'd11);
      step_idle();

      // Timeout with no ack
      access(1'b0, 4'b1111, 3'b010, 5'd3, 32'h400, 32'd0, 32'h11111111, 0, be);
      check("to_burst_len", 32'(be), 32'd16);
      check("to_busError", 32'(busError), 32'd1);
      check("to_stall", 32'(stallRequest), 32'd0);
      check("to_valid", 32'(loadResultValid), 32'd0);
      @(negedge clk);
      check("to_busError_hold", 32'(busError), 32'd1);
      check("to_result_kept", loadResult, 32'h0BADF00D);
      step_idle();

      // Ack on the last allowed cycle beats the timeout
      access(1'b0, 4'b1111, 3'b010, 5'd4, 32'h404, 32'd0, 32'h22222222, 16, be);
      check("ack16_burst_len", 32'(be), 32'd16);
      check("ack16_busError", 32'(busError), 32'd0);
      check("ack16_valid", 32'(loadResultValid), 32'd1);
      check("ack16_result", loadResult, 32'h22222222);
      step_idle();

      // Reset during the 2nd bus cycle, then a stray ack
      @(negedge clk);
      memoryEnable = 1'b1; memoryWriteEnable = 1'b0; memoryByteSelect = 4'b1111;
      loadFunct3 = 3'b010; memoryAddress = 32'h500; loadRdIndex = 5'd5;
      @(negedge clk);
      check("rb_bus1", 32'(bus_enable), 32'd1);
      @(negedge clk);
      check("rb_bus2", 32'(bus_enable), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rb_async_bus_enable", 32'(bus_enable), 32'd0);
      check("rb_async_stall", 32'(stallRequest), 32'd0);
      check("rb_async_result", loadResult, 32'd0);
      memoryEnable = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bus_ack = 1'b1; bus_readData = 32'hFFFFFFFF;
      @(negedge clk);
      bus_ack = 1'b0;
      check("rb_late_ack_valid", 32'(loadResultValid), 32'd0);
      check("rb_late_ack_bus", 32'(bus_enable), 32'd0);
      check("rb_late_ack_stall", 32'(stallRequest), 32'd0);
      check("rb_late_ack_result", loadResult, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
